// File: rtl/circle_pkg.sv
// ---------------------------------------------------------------------------
// circle_pkg
// Shared types and width helpers for the midpoint circle/arc rasteriser.
//   state_t   : drawing FSM states
//   OCTANTS   : number of octants walked per midpoint iteration
//   K_W       : width of the octant counter
//   off_w()   : signed width of the ox/oy offsets for a given radius width
//   crit_w()  : signed width of the midpoint decision criterion
// ---------------------------------------------------------------------------
package circle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    PLOT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int OCTANTS = 8;
  localparam int K_W     = 3;

  // One extra bit so ox can step below zero on the final update.
  function automatic int off_w(input int r_w);
    return r_w + 1;
  endfunction

  // Criterion grows to roughly 4*radius, so three bits of headroom.
  function automatic int crit_w(input int r_w);
    return r_w + 3;
  endfunction

endpackage : circle_pkg

// File: rtl/circle_octant_map.sv
// ---------------------------------------------------------------------------
// circle_octant_map
// Combinational mapping of a first-octant offset (ox, oy) onto octant k
// around centre (cx, cy), with an on-screen flag for clipping.
// Ports:
//   cx, cy     : unsigned circle centre
//   ox, oy     : signed offsets (R_W+1 bits)
//   k          : octant index 0..7
//   x, y       : signed pixel coordinate, two bits wider than the screen
//                coordinate so neither the sum nor the difference wraps
//   on_screen  : 1 when 0 <= x < X_MAX and 0 <= y < Y_MAX
// ---------------------------------------------------------------------------
module circle_octant_map
  import circle_pkg::*;
#(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120,
  parameter int R_W   = 8
) (
  input  logic [X_W-1:0]             cx,
  input  logic [Y_W-1:0]             cy,
  input  logic signed [off_w(R_W)-1:0] ox,
  input  logic signed [off_w(R_W)-1:0] oy,
  input  logic [K_W-1:0]             k,
  output logic signed [X_W+1:0]      x,
  output logic signed [Y_W+1:0]      y,
  output logic                       on_screen
);

  localparam int XE = X_W + 2;
  localparam int YE = Y_W + 2;
  localparam logic signed [XE-1:0] X_LIM = XE'(X_MAX);
  localparam logic signed [YE-1:0] Y_LIM = YE'(Y_MAX);

  logic signed [XE-1:0] cx_s, ox_x_s, oy_x_s;
  logic signed [YE-1:0] cy_s, ox_y_s, oy_y_s;

  // Extend operands to coordinate width, select the octant, then clip.
  always_comb begin
    cx_s   = $signed(XE'(cx));
    cy_s   = $signed(YE'(cy));
    ox_x_s = XE'(ox);
    oy_x_s = XE'(oy);
    ox_y_s = YE'(ox);
    oy_y_s = YE'(oy);
    x      = cx_s;
    y      = cy_s;
    case (k)
      3'd0: begin x = cx_s + ox_x_s; y = cy_s + oy_y_s; end
      3'd1: begin x = cx_s + oy_x_s; y = cy_s + ox_y_s; end
      3'd2: begin x = cx_s - oy_x_s; y = cy_s + ox_y_s; end
      3'd3: begin x = cx_s - ox_x_s; y = cy_s + oy_y_s; end
      3'd4: begin x = cx_s - ox_x_s; y = cy_s - oy_y_s; end
      3'd5: begin x = cx_s - oy_x_s; y = cy_s - ox_y_s; end
      3'd6: begin x = cx_s + oy_x_s; y = cy_s - ox_y_s; end
      3'd7: begin x = cx_s + ox_x_s; y = cy_s - oy_y_s; end
      default: begin x = cx_s; y = cy_s; end
    endcase
    on_screen = !x[XE-1] && (x < X_LIM) && !y[YE-1] && (y < Y_LIM);
  end

endmodule : circle_octant_map

// File: rtl/circle_arc_draw.sv
// ---------------------------------------------------------------------------
// circle_arc_draw
// Midpoint circle/arc rasteriser: one octant pixel per clock, octant mask for
// arcs, clipping against the screen, fixed 8 cycles per midpoint iteration.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : level request, held until done is seen
//   centre_x/y   : circle centre (sampled in INIT only)
//   radius       : radius in pixels (sampled in INIT only)
//   colour       : pixel colour (sampled in INIT only)
//   octant_mask  : bit k enables octant k (sampled in INIT only)
//   done         : drawing complete, held while start stays high
//   vga_x/vga_y  : pixel coordinate of the current PLOT cycle
//   vga_colour   : latched colour
//   vga_plot     : write strobe for the current pixel
// All outputs are registers. The pixel for the next cycle is computed ahead
// of time so the output registers line up with the PLOT state itself.
// ---------------------------------------------------------------------------
module circle_arc_draw
  import circle_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int X_MAX    = 160,
  parameter int Y_MAX    = 120,
  parameter int COLOUR_W = 3,
  parameter int R_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [X_W-1:0]      centre_x,
  input  logic [Y_W-1:0]      centre_y,
  input  logic [R_W-1:0]      radius,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [OCTANTS-1:0]  octant_mask,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam int OW = off_w(R_W);
  localparam int CW = crit_w(R_W);

  state_t                state_r;
  logic [X_W-1:0]        cx_r;
  logic [Y_W-1:0]        cy_r;
  logic [OCTANTS-1:0]    mask_r;
  logic signed [OW-1:0]  ox_r, oy_r;
  logic signed [CW-1:0]  crit_r;
  logic [K_W-1:0]        k_r;

  logic signed [OW-1:0]  upd_ox_s, upd_oy_s;
  logic signed [CW-1:0]  step_s, upd_crit_s;
  logic                  exit_s;

  logic [X_W-1:0]        map_cx_s;
  logic [Y_W-1:0]        map_cy_s;
  logic signed [OW-1:0]  map_ox_s, map_oy_s;
  logic [K_W-1:0]        map_k_s;
  logic [OCTANTS-1:0]    map_mask_s;
  logic signed [X_W+1:0] map_x_s;
  logic signed [Y_W+1:0] map_y_s;
  logic                  on_screen_s;

  // Midpoint step applied after octant 7; exit once oy passes ox.
  always_comb begin
    upd_oy_s = oy_r + OW'(1);
    if (crit_r[CW-1] || (crit_r == '0)) begin
      upd_ox_s = ox_r;
      step_s   = CW'(upd_oy_s);
    end else begin
      upd_ox_s = ox_r - OW'(1);
      step_s   = CW'(upd_oy_s) - CW'(upd_ox_s);
    end
    upd_crit_s = crit_r + (step_s <<< 1) + CW'(1);
    exit_s     = (upd_oy_s > upd_ox_s);
  end

  // Select the point that will be presented on the outputs next cycle.
  always_comb begin
    map_cx_s   = cx_r;
    map_cy_s   = cy_r;
    map_ox_s   = ox_r;
    map_oy_s   = oy_r;
    map_k_s    = k_r + 3'd1;
    map_mask_s = mask_r;
    case (state_r)
      INIT: begin
        map_cx_s   = centre_x;
        map_cy_s   = centre_y;
        map_ox_s   = OW'(radius);
        map_oy_s   = '0;
        map_k_s    = 3'd0;
        map_mask_s = octant_mask;
      end
      PLOT: begin
        if (k_r == 3'd7) begin
          map_ox_s = upd_ox_s;
          map_oy_s = upd_oy_s;
          map_k_s  = 3'd0;
        end else begin
          map_k_s  = k_r + 3'd1;
        end
      end
      default: begin
        map_k_s = k_r + 3'd1;
      end
    endcase
  end

  circle_octant_map #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX),
    .R_W   (R_W)
  ) u_map (
    .cx        (map_cx_s),
    .cy        (map_cy_s),
    .ox        (map_ox_s),
    .oy        (map_oy_s),
    .k         (map_k_s),
    .x         (map_x_s),
    .y         (map_y_s),
    .on_screen (on_screen_s)
  );

  // Drawing FSM with offset/criterion state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cx_r       <= '0;
      cy_r       <= '0;
      mask_r     <= '0;
      ox_r       <= '0;
      oy_r       <= '0;
      crit_r     <= '0;
      k_r        <= '0;
      done       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done     <= 1'b0;
          vga_plot <= 1'b0;
          if (start) begin
            state_r <= INIT;
          end else begin
            state_r <= IDLE;
          end
        end
        INIT: begin
          cx_r       <= centre_x;
          cy_r       <= centre_y;
          mask_r     <= octant_mask;
          vga_colour <= colour;
          ox_r       <= OW'(radius);
          oy_r       <= '0;
          crit_r     <= CW'(1) - CW'(radius);
          k_r        <= 3'd0;
          vga_x      <= map_x_s[X_W-1:0];
          vga_y      <= map_y_s[Y_W-1:0];
          vga_plot   <= map_mask_s[map_k_s] & on_screen_s;
          state_r    <= PLOT;
        end
        PLOT: begin
          if ((k_r == 3'd7) && exit_s) begin
            ox_r     <= upd_ox_s;
            oy_r     <= upd_oy_s;
            crit_r   <= upd_crit_s;
            vga_plot <= 1'b0;
            done     <= 1'b1;
            state_r  <= DONE;
          end else begin
            if (k_r == 3'd7) begin
              ox_r   <= upd_ox_s;
              oy_r   <= upd_oy_s;
              crit_r <= upd_crit_s;
            end else begin
              ox_r   <= ox_r;
            end
            k_r      <= map_k_s;
            vga_x    <= map_x_s[X_W-1:0];
            vga_y    <= map_y_s[Y_W-1:0];
            vga_plot <= map_mask_s[map_k_s] & on_screen_s;
            state_r  <= PLOT;
          end
        end
        DONE: begin
          vga_plot <= 1'b0;
          if (!start) begin
            done    <= 1'b0;
            state_r <= IDLE;
          end else begin
            done    <= 1'b1;
            state_r <= DONE;
          end
        end
        default: begin
          done     <= 1'b0;
          vga_plot <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule : circle_arc_draw

// File: tb/tb_circle_arc_draw.sv
// ---------------------------------------------------------------------------
// tb_circle_arc_draw
// Two instances: default 160x120 screen (A) and a 320x240, 9-bit colour
// screen (B). A reference model walks the midpoint circle with integer
// arithmetic and queues every pixel that should be plotted; per-instance
// monitors pop and compare on each vga_plot strobe.
// ---------------------------------------------------------------------------
module tb_circle_arc_draw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b;
  logic [8:0] cx;
  logic [7:0] cy;
  logic [7:0] radius;
  logic [8:0] colour;
  logic [7:0] mask;

  logic       done_a, plot_a;
  logic [7:0] vx_a;
  logic [6:0] vy_a;
  logic [2:0] vc_a;
  logic       done_b, plot_b;
  logic [8:0] vx_b;
  logic [7:0] vy_b;
  logic [8:0] vc_b;

  circle_arc_draw dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .centre_x(cx[7:0]), .centre_y(cy[6:0]), .radius(radius),
    .colour(colour[2:0]), .octant_mask(mask),
    .done(done_a), .vga_x(vx_a), .vga_y(vy_a),
    .vga_colour(vc_a), .vga_plot(plot_a)
  );

  circle_arc_draw #(
    .X_W(9), .Y_W(8), .X_MAX(320), .Y_MAX(240), .COLOUR_W(9), .R_W(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .centre_x(cx), .centre_y(cy), .radius(radius),
    .colour(colour), .octant_mask(mask),
    .done(done_b), .vga_x(vx_b), .vga_y(vy_b),
    .vga_colour(vc_b), .vga_plot(plot_b)
  );

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t qa[$];
  pix_t qb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   plots_a  = 0;
  int   plots_b  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for instance A
  always @(negedge clk) begin : mon_a
    pix_t p;
    if (rst_n === 1'b1 && plot_a === 1'b1) begin
      plots_a++;
      if (qa.size() == 0) begin
        check("a_unexpected_plot", 1, 0);
      end else begin
        p = qa.pop_front();
        check("a_x", int'(vx_a), p.x);
        check("a_y", int'(vy_a), p.y);
        check("a_colour", int'(vc_a), p.c);
      end
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin : mon_b
    pix_t p;
    if (rst_n === 1'b1 && plot_b === 1'b1) begin
      plots_b++;
      if (qb.size() == 0) begin
        check("b_unexpected_plot", 1, 0);
      end else begin
        p = qb.pop_front();
        check("b_x", int'(vx_b), p.x);
        check("b_y", int'(vy_b), p.y);
        check("b_colour", int'(vc_b), p.c);
      end
    end
  end

  // Reference: integer midpoint walk, eight octant reflections, mask, clip.
  task automatic build_expect(input bit sel, input int cxv, input int cyv,
                              input int r, input int col, input int m,
                              output int iters, output int nplots);
    int   xmax, ymax, ox, oy, crit;
    int   px[8];
    int   py[8];
    pix_t p;
    xmax = sel ? 320 : 160;
    ymax = sel ? 240 : 120;
    ox = r; oy = 0; crit = 1 - r;
    iters = 0; nplots = 0;
    while (oy <= ox) begin
      iters++;
      px = '{cxv+ox, cxv+oy, cxv-oy, cxv-ox, cxv-ox, cxv-oy, cxv+oy, cxv+ox};
      py = '{cyv+oy, cyv+ox, cyv+ox, cyv+oy, cyv-oy, cyv-ox, cyv-ox, cyv-oy};
      for (int k = 0; k < 8; k++) begin
        if (m[k] && px[k] >= 0 && px[k] < xmax && py[k] >= 0 && py[k] < ymax) begin
          p.x = px[k];
          p.y = py[k];
          p.c = col & (sel ? 511 : 7);
          if (sel) qb.push_back(p);
          else     qa.push_back(p);
          nplots++;
        end
      end
      oy++;
      if (crit <= 0) begin
        crit += 2 * oy + 1;
      end else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end
  endtask

  task automatic set_start(input bit sel, input bit v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  function automatic int cur_done(input bit sel);
    return sel ? int'(done_b) : int'(done_a);
  endfunction

  function automatic int cur_plot(input bit sel);
    return sel ? int'(plot_b) : int'(plot_a);
  endfunction

  function automatic int plot_count(input bit sel);
    return sel ? plots_b : plots_a;
  endfunction

  // One draw: latency, done handshake, plot count, queue drained.
  task automatic run(input bit sel, input int cxv, input int cyv, input int r,
                     input int col, input int m, input bit drop_early,
                     input bit scramble, input int fixed_plots, input bit do_reset);
    int iters, nplots, base, edges;
    cx = 9'(cxv); cy = 8'(cyv); radius = 8'(r); colour = 9'(col); mask = 8'(m);
    build_expect(sel, cxv, cyv, r, col, m, iters, nplots);
    base = plot_count(sel);
    set_start(sel, 1'b1);
    if (do_reset) begin
      repeat (30) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_done", int'(done_a), 0);
      check("rst_mid_plot", int'(plot_a), 0);
      check("rst_mid_x", int'(vx_a), 0);
      check("rst_mid_y", int'(vy_a), 0);
      check("rst_mid_colour", int'(vc_a), 0);
      rst_n = 1'b1;
      if (sel) qb.delete();
      else     qa.delete();
      build_expect(sel, cxv, cyv, r, col, m, iters, nplots);
      base = plot_count(sel);
    end
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (scramble && edges == 3) begin
        cx = 9'($urandom); cy = 8'($urandom); radius = 8'($urandom);
        colour = 9'($urandom); mask = 8'($urandom);
      end
      if (drop_early && edges == 4) set_start(sel, 1'b0);
    end while (cur_done(sel) == 0 && edges < 3000);
    check("done_latency", edges, 2 + 8 * iters);
    if (drop_early) begin
      @(posedge clk);
      #1;
      check("done_pulse_drop", cur_done(sel), 0);
    end else begin
      repeat (3) begin
        @(posedge clk);
        #1;
        check("done_held", cur_done(sel), 1);
        check("plot_low_in_done", cur_plot(sel), 0);
      end
      set_start(sel, 1'b0);
      @(posedge clk);
      #1;
      check("done_drop", cur_done(sel), 0);
    end
    @(posedge clk);
    #1;
    check("queue_drained", sel ? qb.size() : qa.size(), 0);
    check("plot_count", plot_count(sel) - base, nplots);
    if (fixed_plots >= 0) check("plot_count_fixed", plot_count(sel) - base, fixed_plots);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    cx = '0; cy = '0; radius = '0; colour = '0; mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done_a", int'(done_a), 0);
    check("reset_plot_a", int'(plot_a), 0);
    check("reset_x_a", int'(vx_a), 0);
    check("reset_y_a", int'(vy_a), 0);
    check("reset_colour_a", int'(vc_a), 0);
    check("reset_done_b", int'(done_b), 0);
    check("reset_plot_b", int'(plot_b), 0);
    check("reset_colour_b", int'(vc_b), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(1'b0, 80, 60, 0, 5, 8'hFF, 1'b0, 1'b0, 8, 1'b0);
    run(1'b0, 80, 60, 1, 3, 8'hFF, 1'b0, 1'b0, 16, 1'b0);
    run(1'b0, 0, 0, 10, 7, 8'hFF, 1'b0, 1'b0, 18, 1'b0);
    run(1'b0, 80, 60, 10, 2, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    run(1'b0, 80, 60, 10, 6, 8'h0F, 1'b0, 1'b1, -1, 1'b0);
    run(1'b0, 80, 60, 20, 4, 8'hFF, 1'b0, 1'b0, -1, 1'b1);
    run(1'b0, 70, 50, 15, 1, 8'hA5, 1'b1, 1'b0, -1, 1'b0);
    run(1'b0, 155, 115, 12, 3, 8'hFF, 1'b0, 1'b0, -1, 1'b0);
    run(1'b1, 300, 200, 30, 9'h1A5, 8'hFF, 1'b0, 1'b0, -1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run(1'b0, int'($urandom_range(255, 0)), int'($urandom_range(127, 0)),
          int'($urandom_range(40, 0)), int'($urandom_range(7, 0)),
          int'($urandom_range(255, 0)), 1'b0, 1'b1, -1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      run(1'b1, int'($urandom_range(511, 0)), int'($urandom_range(255, 0)),
          int'($urandom_range(40, 0)), int'($urandom_range(511, 0)),
          int'($urandom_range(255, 0)), 1'b0, 1'b1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_circle_arc_draw
